// File: rtl/serial_adder.sv
// Multi-cycle add/subtract of WIDTH-bit operands through a DIGIT-bit slice, N=WIDTH/DIGIT RUN cycles; SERADD_OVF_EN adds ovf.
// Latency: done/s/co N edges after start is accepted; start is only taken in IDLE or DONE and ignored while busy.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             ck,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
`ifdef SERADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                 state_q, state_d;
   logic [WIDTH-1:0]       opa_q, opa_d;
   logic [WIDTH-1:0]       opb_q, opb_d;
   logic [WIDTH-1:0]       acc_q, acc_d;
   logic [WIDTH-1:0]       s_q, s_d;
   logic                   carry_q, carry_d;
   logic                   co_q, co_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [DIGIT:0]         dsum;
   logic [WIDTH+DIGIT-1:0] shift_in;
   logic                   last;
`ifdef SERADD_OVF_EN
   logic                   ovf_q, ovf_d;
   logic                   msb_cin;
`endif

   always_comb begin
      dsum     = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
      shift_in = {dsum[DIGIT-1:0], acc_q};
      last     = (cnt_q == CW'(N - 1));
`ifdef SERADD_OVF_EN
      // Carry into the MSB is recovered from the MSB's own sum bit in the final digit.
      msb_cin  = opa_q[DIGIT-1] ^ opb_q[DIGIT-1] ^ dsum[DIGIT-1];
      ovf_d    = ovf_q;
`endif
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      s_d      = s_q;
      carry_d  = carry_q;
      co_d     = co_q;
      cnt_d    = cnt_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = ci ^ sub;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            acc_d   = shift_in[WIDTH+DIGIT-1:DIGIT];
            carry_d = dsum[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               s_d     = shift_in[WIDTH+DIGIT-1:DIGIT];
               co_d    = dsum[DIGIT];
`ifdef SERADD_OVF_EN
               ovf_d   = msb_cin ^ dsum[DIGIT];
`endif
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         acc_q   <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         co_q    <= 1'b0;
         cnt_q   <= '0;
`ifdef SERADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         co_q    <= co_d;
         cnt_q   <= cnt_d;
`ifdef SERADD_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign co   = co_q;
`ifdef SERADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (DIGIT=1,4,2 at WIDTH=8) checked every cycle against a countdown/arithmetic model.
// Directed vectors with hand-computed literal results; ovf checks only when SERADD_OVF_EN is defined.
module tb_serial_adder;

   localparam int NI = 3;

   logic       ck = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] start = '0;
   logic       sub = 1'b0;
   logic       ci = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic [2:0] busy, done, co;
   logic [7:0] s [NI];
`ifdef SERADD_OVF_EN
   logic [2:0] ovf;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   always #5 ck = ~ck;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .ck(ck), .rst(rst), .start(start[0]), .sub(sub), .a(a), .b(b), .ci(ci),
      .busy(busy[0]), .done(done[0]), .s(s[0]), .co(co[0])
`ifdef SERADD_OVF_EN
      , .ovf(ovf[0])
`endif
   );
   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .ck(ck), .rst(rst), .start(start[1]), .sub(sub), .a(a), .b(b), .ci(ci),
      .busy(busy[1]), .done(done[1]), .s(s[1]), .co(co[1])
`ifdef SERADD_OVF_EN
      , .ovf(ovf[1])
`endif
   );
   serial_adder #(.WIDTH(8), .DIGIT(2)) u_d2 (
      .ck(ck), .rst(rst), .start(start[2]), .sub(sub), .a(a), .b(b), .ci(ci),
      .busy(busy[2]), .done(done[2]), .s(s[2]), .co(co[2])
`ifdef SERADD_OVF_EN
      , .ovf(ovf[2])
`endif
   );

   function automatic int iters(input int i);
      return (i == 0) ? 8 : (i == 1) ? 2 : 4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: an accepted operation produces its full-width sum after iters() edges, then done for one cycle.
   int         m_rem  [NI] = '{default: 0};
   bit         m_done [NI] = '{default: 0};
   logic [8:0] m_res  [NI] = '{default: '0};
   logic [8:0] m_pend [NI] = '{default: '0};
   bit         m_ovf  [NI] = '{default: 0};
   bit         m_povf [NI] = '{default: 0};
   logic [7:0] m_ob;

   always @(posedge ck or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            m_rem[i] = 0; m_done[i] = 0; m_res[i] = '0; m_ovf[i] = 0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (m_rem[i] > 0) begin
               m_rem[i]--;
               if (m_rem[i] == 0) begin
                  m_res[i]  = m_pend[i];
                  m_ovf[i]  = m_povf[i];
                  m_done[i] = 1;
               end
            end else begin
               m_done[i] = 0;
               if (start[i]) begin
                  m_ob      = sub ? ~b : b;
                  m_pend[i] = {1'b0, a} + {1'b0, m_ob} + 9'(ci ^ sub);
                  m_povf[i] = (a[7] == m_ob[7]) && (m_pend[i][7] != a[7]);
                  m_rem[i]  = iters(i);
               end
            end
         end
      end
   end

   always @(negedge ck) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_rem[i] > 0));
            chk($sformatf("done%0d", i), 32'(done[i]), 32'(m_done[i]));
            chk($sformatf("s%0d", i), 32'(s[i]), 32'(m_res[i][7:0]));
            chk($sformatf("co%0d", i), 32'(co[i]), 32'(m_res[i][8]));
`ifdef SERADD_OVF_EN
            chk($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(m_ovf[i]));
`endif
         end
      end
   end

   task automatic wait_done(input int i);
      int t;
      t = 0;
      while (!done[i] && t < 40) begin
         @(negedge ck);
         t++;
      end
      chk($sformatf("done_seen%0d", i), 32'(done[i]), 32'd1);
   endtask

   task automatic run_op(input int i, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic tci, input logic tsub);
      a = ta; b = tb_v; ci = tci; sub = tsub;
      start[i] = 1'b1;
      @(posedge ck); #1;
      start[i] = 1'b0;
      wait_done(i);
   endtask

   task automatic realign();
      @(posedge ck); #1;
   endtask

   initial begin
      int ndone;
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_s0", 32'(s[0]), 32'd0);
      chk("rst_co", 32'(co), 32'd0);
      @(posedge ck); #1;
      rst = 1'b1;

      // FF + 01 wraps to 00 with carry out
      run_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
      chk("add_ff_s", 32'(s[0]), 32'h00);
      chk("add_ff_co", 32'(co[0]), 32'd1);
      realign();
      chk("done_one_cycle", 32'(done[0]), 32'd0);

      run_op(0, 8'h05, 8'h07, 1'b0, 1'b1);
      chk("sub_5_7_s", 32'(s[0]), 32'hFE);
      chk("sub_5_7_co", 32'(co[0]), 32'd0);
      realign();
      run_op(0, 8'h07, 8'h05, 1'b1, 1'b1);
      chk("sub_7_5_s", 32'(s[0]), 32'h01);
      chk("sub_7_5_co", 32'(co[0]), 32'd1);
      realign();

      // DIGIT=4 with start held through DONE for a back-to-back second operation
      a = 8'h3C; b = 8'h5A; ci = 1'b1; sub = 1'b0; start[1] = 1'b1;
      @(posedge ck); #1;
      a = 8'h01; b = 8'h01; ci = 1'b0;
      wait_done(1);
      chk("d4_s", 32'(s[1]), 32'h97);
      chk("d4_co", 32'(co[1]), 32'd0);
      realign();
      start[1] = 1'b0;
      chk("d4_b2b_busy", 32'(busy[1]), 32'd1);
      wait_done(1);
      chk("d4_b2b_s", 32'(s[1]), 32'h02);
      realign();

      // start during RUN is ignored
      a = 8'h21; b = 8'h13; ci = 1'b0; sub = 1'b0; start[0] = 1'b1;
      @(posedge ck); #1;
      start[0] = 1'b0;
      @(posedge ck); #1;
      a = 8'hAA; b = 8'h55; sub = 1'b1; start[0] = 1'b1;
      @(posedge ck); #1;
      start[0] = 1'b0;
      wait_done(0);
      chk("ign_s", 32'(s[0]), 32'h34);
      chk("ign_co", 32'(co[0]), 32'd0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge ck);
         if (done[0]) ndone++;
      end
      chk("ign_extra_done", 32'(ndone), 32'd0);
      realign();

      // asynchronous reset in the middle of RUN
      a = 8'h40; b = 8'h41; ci = 1'b0; sub = 1'b0; start[0] = 1'b1;
      @(posedge ck); #1;
      start[0] = 1'b0;
      repeat (3) @(posedge ck);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      chk("mid_rst_done", 32'(done[0]), 32'd0);
      chk("mid_rst_s", 32'(s[0]), 32'd0);
      chk("mid_rst_co", 32'(co[0]), 32'd0);
      @(negedge ck);
      rst = 1'b1;
      run_op(0, 8'h12, 8'h34, 1'b0, 1'b0);
      chk("post_rst_s", 32'(s[0]), 32'h46);
      realign();

      // DIGIT=2 signed-overflow cases
      run_op(2, 8'h7F, 8'h01, 1'b0, 1'b0);
      chk("d2_7f_s", 32'(s[2]), 32'h80);
`ifdef SERADD_OVF_EN
      chk("d2_7f_ovf", 32'(ovf[2]), 32'd1);
`endif
      realign();
      run_op(2, 8'h80, 8'h01, 1'b0, 1'b1);
      chk("d2_80_s", 32'(s[2]), 32'h7F);
      chk("d2_80_co", 32'(co[2]), 32'd1);
`ifdef SERADD_OVF_EN
      chk("d2_80_ovf", 32'(ovf[2]), 32'd1);
`endif
      realign();
      run_op(2, 8'h10, 8'h20, 1'b0, 1'b0);
      chk("d2_10_s", 32'(s[2]), 32'h30);
`ifdef SERADD_OVF_EN
      chk("d2_10_ovf", 32'(ovf[2]), 32'd0);
`endif
      realign();
      repeat (2) @(posedge ck);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's registered 1-bit full adder.
- Adds or subtracts two WIDTH-bit operands using a DIGIT-bit full-adder slice, iterated WIDTH/DIGIT times, with a carry register between iterations.
- Start/busy/done handshake; sum and carry are held in output registers until the next completion.
- Used where area matters more than latency, e.g. accumulators in small datapaths.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH evenly. N = WIDTH/DIGIT iterations.

Ports:
- ck  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  request an operation; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b+ci; 1 = a+~b+~ci, i.e. a-b-borrow with ci as the borrow.
- a  input  WIDTH  operand A; captured when start is accepted.
- b  input  WIDTH  operand B; captured when start is accepted.
- ci  input  1  carry-in (add) or borrow-in (sub); captured when start is accepted.
- busy  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse; high only in the DONE state.
- s  output  WIDTH  result register.
- co  output  1  carry-out. In sub mode, 1 means no borrow.
- ovf  output  1  signed overflow; present only with SERADD_OVF_EN.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, s=0, co=0, ovf=0. Internal shift and carry registers are cleared.
- States: IDLE, RUN, DONE.
- IDLE with start=1: on that edge, load
  - opA=a
  - opB = sub ? ~b : b
  - carry = ci ^ sub
  - count=0
  - then go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each edge:
  - {carry, digit} = opA[DIGIT-1:0] + opB[DIGIT-1:0] + carry.
  - Shift the digit into the MSB end of the result shift register.
  - Shift opA and opB right by DIGIT.
  - count++.
- RUN exit: on the edge where count==N-1, perform the last digit and go to DONE.
  - s <= completed result; co <= final carry.
  - ovf (if enabled) is updated on the same edge.
- start is ignored while in RUN; no queueing.
- DONE: done=1 for exactly one cycle.
  - Next edge with start=1: load the new operands and go to RUN (back-to-back operation).
  - Next edge with start=0: go to IDLE.
- Latency: start accepted at edge k → s/co valid and done=1 after edge k+N.
- Throughput: one operation per N+1 cycles.
- s and co change only on the RUN→DONE edge or on reset. They are not cleared by start.
- Arithmetic is modulo 2^WIDTH; co is bit WIDTH of the full-width result.
- Operand inputs may change freely after acceptance. Changes to a, b, ci or sub during RUN have no effect.
- Reset asserted mid-RUN: abort immediately. No done pulse; outputs cleared to zero.
- Reset released: the first operation may be accepted on the first rising edge with rst=1.

Optional Feature:
- Macro: SERADD_OVF_EN.
- Defined:
  - ovf port exists.
  - ovf <= carry-in to the MSB XOR carry-out of the MSB, registered on the RUN→DONE edge.
  - Reset value 0; ovf holds alongside s.
- Undefined:
  - ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1, sub=0: a=8'hFF, b=8'h01, ci=0, start pulsed at edge k → busy=1 for edges k+1..k+8; done=1 after edge k+8; s=8'h00, co=1.
- WIDTH=8, DIGIT=1, sub=1: a=8'h05, b=8'h07, ci=0 → s=8'hFE, co=0. Then a=8'h07, b=8'h05, ci=1 → s=8'h01, co=1.
- WIDTH=8, DIGIT=4: a=8'h3C, b=8'h5A, ci=1 → done after 2 RUN edges; s=8'h97, co=0. Start held high in DONE with a=1, b=1 → immediate RUN, s=8'h02 after 2 more edges.
- start pulsed during RUN with different operands → ignored; the original result completes unchanged and there is no second done.
- rst driven low mid-RUN, asynchronously between edges → busy, done, s and co go to 0 immediately, with no done pulse. A new start after release gives the correct result.
- SERADD_OVF_EN defined, WIDTH=8, DIGIT=2: a=8'h7F, b=8'h01, ci=0 → s=8'h80, ovf=1. Then a=8'h80, b=8'h01, sub=1, ci=0 → s=8'h7F, ovf=1. Then a=8'h10, b=8'h20, sub=0 → s=8'h30, ovf=0.
